// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute stage.
// Holds the ALU op codes, the conditional-jump type codes, the bit positions
// of {C,Z,N} in the flag register and the multiply FSM state encoding.
package ex_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_INC  = 4'd6;
    localparam logic [3:0] OP_DEC  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_MOV  = 4'd10;
    localparam logic [3:0] OP_SETC = 4'd11;
    localparam logic [3:0] OP_CLRC = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;

    localparam logic [1:0] JT_NONE = 2'd0;
    localparam logic [1:0] JT_JZ   = 2'd1;
    localparam logic [1:0] JT_JN   = 2'd2;
    localparam logic [1:0] JT_JC   = 2'd3;

    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational ALU core of the execute stage.
// Ports:
//   op        in  4       op code (ex_pkg OP_*); unknown codes and MUL act as NOP
//   a, b      in  DATA_W  operands
//   flags_in  in  3       current {C,Z,N}
//   result    out DATA_W  result, modulo 2^DATA_W
//   flags_out out 3       next {C,Z,N}
module ex_alu
    import ex_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        flags_in,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        flags_out
);

    logic [DATA_W:0] ext;
    logic [3:0]      sh;
    logic            upd_zn;

    always_comb begin
        result    = '0;
        flags_out = flags_in;
        ext       = '0;
        upd_zn    = 1'b0;
        sh        = b[3:0];
        case (op)
            OP_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                result = ext[DATA_W-1:0];
                flags_out[FLAG_C] = ext[DATA_W];
                upd_zn = 1'b1;
            end
            OP_SUB: begin
                // Top bit of the extended difference is the borrow.
                ext = {1'b0, a} - {1'b0, b};
                result = ext[DATA_W-1:0];
                flags_out[FLAG_C] = ext[DATA_W];
                upd_zn = 1'b1;
            end
            OP_AND: begin result = a & b; upd_zn = 1'b1; end
            OP_OR:  begin result = a | b; upd_zn = 1'b1; end
            OP_NOT: begin result = ~a;    upd_zn = 1'b1; end
            OP_INC: begin
                ext = {1'b0, a} + {{DATA_W{1'b0}}, 1'b1};
                result = ext[DATA_W-1:0];
                flags_out[FLAG_C] = ext[DATA_W];
                upd_zn = 1'b1;
            end
            OP_DEC: begin
                ext = {1'b0, a} - {{DATA_W{1'b0}}, 1'b1};
                result = ext[DATA_W-1:0];
                flags_out[FLAG_C] = ext[DATA_W];
                upd_zn = 1'b1;
            end
            OP_SHL: begin
                // The extra MSB catches the last bit shifted out.
                ext = {1'b0, a} << sh;
                result = ext[DATA_W-1:0];
                if (sh != 4'd0) flags_out[FLAG_C] = ext[DATA_W];
                upd_zn = 1'b1;
            end
            OP_SHR: begin
                // The extra LSB catches the last bit shifted out.
                ext = {a, 1'b0} >> sh;
                result = ext[DATA_W:1];
                if (sh != 4'd0) flags_out[FLAG_C] = ext[0];
                upd_zn = 1'b1;
            end
            OP_MOV:  result = b;
            OP_SETC: flags_out[FLAG_C] = 1'b1;
            OP_CLRC: flags_out[FLAG_C] = 1'b0;
            default: ;
        endcase
        if (upd_zn) begin
            flags_out[FLAG_Z] = (result == '0);
            flags_out[FLAG_N] = result[DATA_W-1];
        end
    end

endmodule

// File: rtl/ex_stage_p.sv
// ex_stage_p: execute stage of the pipelined processor.
// Accepts one decoded instruction per cycle, forwards operands from its own
// result history and the memory-stage load path, runs the ALU, updates the
// {C,Z,N} flag register and resolves conditional jumps.
// Build option: define EX_MUL_EN to build the iterative multiplier (op 13);
// without it op 13 executes as NOP and in_ready is simply !rst.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             instruction handshake (in_ready combinational)
//   in_op, in_jump_type           op code, jump type (0 none, 1 JZ, 2 JN, 3 JC)
//   in_use_imm, in_imm            operand B from immediate
//   in_src1/2_addr, in_src1/2_data  source registers and register-file values
//   in_dst_addr, in_wen           destination and write enable
//   fwd_ld_valid/addr/data        load result held by the memory stage
//   flush                         kill incoming instruction, abort multiply
//   out_valid/result/dst_addr/wen registered result
//   out_flags                     flag register {C,Z,N}
//   jump_taken                    one-cycle pulse for a taken conditional jump
module ex_stage_p
    import ex_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int REG_AW    = 3,
    parameter int FWD_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [1:0]        in_jump_type,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_AW-1:0] in_src1_addr,
    input  logic [REG_AW-1:0] in_src2_addr,
    input  logic [DATA_W-1:0] in_src1_data,
    input  logic [DATA_W-1:0] in_src2_data,
    input  logic [REG_AW-1:0] in_dst_addr,
    input  logic              in_wen,
    input  logic              fwd_ld_valid,
    input  logic [REG_AW-1:0] fwd_ld_addr,
    input  logic [DATA_W-1:0] fwd_ld_data,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_dst_addr,
    output logic              out_wen,
    output logic [2:0]        out_flags,
    output logic              jump_taken
);

    logic [FWD_DEPTH-1:0] hist_vld;
    logic [FWD_DEPTH-1:0] hist_wen;
    logic [REG_AW-1:0]    hist_dst [FWD_DEPTH];
    logic [DATA_W-1:0]    hist_res [FWD_DEPTH];

    logic [DATA_W-1:0] opa, opb_reg, opb, alu_res;
    logic [2:0]        alu_flags, jmp_mask;
    logic              jmp_take, accept, is_mul, accept_single;
    logic              mul_done, mul_wen, push;
    logic [DATA_W-1:0] mul_lo, mul_hi, push_res;
    logic [REG_AW-1:0] mul_dst, push_dst;
    logic              push_wen;

    // Operand forwarding: oldest history first so younger hits overwrite,
    // then the load path, and finally history[0] has the last word.
    always_comb begin
        opa     = in_src1_data;
        opb_reg = in_src2_data;
        for (int i = FWD_DEPTH - 1; i >= 1; i--) begin
            if (hist_vld[i] && hist_wen[i] && hist_dst[i] == in_src1_addr) opa = hist_res[i];
            if (hist_vld[i] && hist_wen[i] && hist_dst[i] == in_src2_addr) opb_reg = hist_res[i];
        end
        if (fwd_ld_valid && fwd_ld_addr == in_src1_addr) opa = fwd_ld_data;
        if (fwd_ld_valid && fwd_ld_addr == in_src2_addr) opb_reg = fwd_ld_data;
        if (hist_vld[0] && hist_wen[0] && hist_dst[0] == in_src1_addr) opa = hist_res[0];
        if (hist_vld[0] && hist_wen[0] && hist_dst[0] == in_src2_addr) opb_reg = hist_res[0];
    end

    assign opb = in_use_imm ? in_imm : opb_reg;

    ex_alu #(.DATA_W(DATA_W)) u_alu (
        .op        (in_op),
        .a         (opa),
        .b         (opb),
        .flags_in  (out_flags),
        .result    (alu_res),
        .flags_out (alu_flags)
    );

    // Jumps test the flag register before this instruction's update.
    always_comb begin
        jmp_take = 1'b0;
        jmp_mask = 3'b000;
        case (in_jump_type)
            JT_JZ: begin jmp_take = out_flags[FLAG_Z]; jmp_mask[FLAG_Z] = 1'b1; end
            JT_JN: begin jmp_take = out_flags[FLAG_N]; jmp_mask[FLAG_N] = 1'b1; end
            JT_JC: begin jmp_take = out_flags[FLAG_C]; jmp_mask[FLAG_C] = 1'b1; end
            default: ;
        endcase
    end

    assign accept        = in_valid && in_ready && !flush;
    assign accept_single = accept && !is_mul;

`ifdef EX_MUL_EN
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    mul_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] acc_q, mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic                mul_step, mul_wen_q;
    logic [REG_AW-1:0]   mul_dst_q;

    assign is_mul = (in_op == OP_MUL);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && is_mul) state_d = ST_MUL;
            ST_MUL: begin
                if (flush)                             state_d = ST_IDLE;
                else if (cnt_q == CNT_W'(DATA_W - 1))  state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = !rst && (state_q == ST_IDLE);
        mul_step = (state_q == ST_MUL) && !flush;
        mul_done = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst)                   cnt_q <= '0;
        else if (accept && is_mul) cnt_q <= '0;
        else if (mul_step)         cnt_q <= cnt_q + CNT_W'(1);
    end

    // Shift-add multiply: one multiplier bit per cycle, LSB first.
    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            acc_q     <= '0;
            mcand_q   <= {{DATA_W{1'b0}}, opa};
            mplier_q  <= opb;
            mul_dst_q <= in_dst_addr;
            mul_wen_q <= in_wen;
        end else if (mul_step) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    assign mul_lo  = acc_q[DATA_W-1:0];
    assign mul_hi  = acc_q[2*DATA_W-1:DATA_W];
    assign mul_dst = mul_dst_q;
    assign mul_wen = mul_wen_q;
`else
    assign is_mul   = 1'b0;
    assign in_ready = !rst;
    assign mul_done = 1'b0;
    assign mul_lo   = '0;
    assign mul_hi   = '0;
    assign mul_dst  = '0;
    assign mul_wen  = 1'b0;
`endif

    assign push     = mul_done || accept_single;
    assign push_res = mul_done ? mul_lo  : alu_res;
    assign push_dst = mul_done ? mul_dst : in_dst_addr;
    assign push_wen = mul_done ? mul_wen : in_wen;

    // ---- execute -> output register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_dst_addr <= '0;
            out_wen      <= 1'b0;
            out_flags    <= 3'b000;
            jump_taken   <= 1'b0;
            hist_vld     <= '0;
            hist_wen     <= '0;
        end else begin
            out_valid  <= push;
            out_wen    <= push && push_wen;
            jump_taken <= accept_single && jmp_take;
            if (push) begin
                out_result   <= push_res;
                out_dst_addr <= push_dst;
                for (int i = FWD_DEPTH - 1; i >= 1; i--) begin
                    hist_vld[i] <= hist_vld[i-1];
                    hist_wen[i] <= hist_wen[i-1];
                end
                hist_vld[0] <= 1'b1;
                hist_wen[0] <= push_wen;
            end
            if (mul_done) begin
                out_flags[FLAG_C] <= (mul_hi != '0);
                out_flags[FLAG_Z] <= (mul_lo == '0);
                out_flags[FLAG_N] <= mul_lo[DATA_W-1];
            end else if (accept_single) begin
                out_flags <= alu_flags & ~(jmp_take ? jmp_mask : 3'b000);
            end
        end
    end

    // History payload carries no reset; hist_vld guards its use.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = FWD_DEPTH - 1; i >= 1; i--) begin
                hist_dst[i] <= hist_dst[i-1];
                hist_res[i] <= hist_res[i-1];
            end
            hist_dst[0] <= push_dst;
            hist_res[0] <= push_res;
        end
    end

endmodule
